// File: rtl/spi_ram_wrapper_param.sv
// SPI-framed 2**W x W RAM: write address / write data / read address / read data
// frames of W+2 bits, MSB first, all sampled on clk.
module spi_ram_wrapper_param #(
  parameter int W        = 8,
  parameter bit AUTO_INC = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);
  localparam int FL = W + 2;
  localparam int CW = $clog2(2 * W + 4);
  localparam logic [CW-1:0] FL_C   = CW'(FL);
  localparam logic [CW-1:0] LAST_C = CW'(FL + W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [FL-1:0] rx;
  logic [W-1:0]  tx, tx_sh, wr_addr, rd_addr, pay;
  logic [1:0]    cmd;
  logic          rd_flag;
  logic          sample, frame_end, wr_set, wr_mem, rd_set, rd_load, rd_shift, rd_done;
  logic [W-1:0]  mem [2**W];

  assign cmd   = rx[FL-1:W];
  assign pay   = rx[W-1:0];
  assign tx_sh = tx << 1;

  always_comb begin
    nxt       = state;
    sample    = 1'b0;
    frame_end = 1'b0;
    rd_shift  = 1'b0;
    if (state != IDLE && SS_n) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!SS_n) nxt = CHK_CMD;
        CHK_CMD: begin
          sample = 1'b1;
          if (!MOSI)       nxt = WRITE;
          else if (rd_flag) nxt = READ_DATA;
          else             nxt = READ_ADD;
        end
        default: begin
          // cnt parks at FL+1 once a frame is done; only an accepted read keeps counting
          sample    = (cnt < FL_C);
          frame_end = (cnt == FL_C);
          rd_shift  = (state == READ_DATA) && (cmd == 2'b11) && (cnt > FL_C) && (cnt <= LAST_C);
        end
      endcase
    end
    wr_set    = frame_end && (state == WRITE)     && (cmd == 2'b00);
    wr_mem    = frame_end && (state == WRITE)     && (cmd == 2'b01);
    rd_set    = frame_end && (state == READ_ADD)  && (cmd == 2'b10);
    rd_load   = frame_end && (state == READ_DATA) && (cmd == 2'b11);
    rd_done   = rd_shift && (cnt == LAST_C);
    frame_err = frame_end && (((state == READ_ADD)  && (cmd == 2'b11)) ||
                              ((state == READ_DATA) && (cmd == 2'b10)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rx      <= '0;
      tx      <= '0;
      MISO    <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      rd_flag <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == IDLE) begin
        cnt  <= '0;
        MISO <= 1'b0;
      end else if (sample || frame_end || rd_shift) begin
        cnt <= cnt + CW'(1);
      end
      if (sample) rx <= {rx[FL-2:0], MOSI};
      if (wr_set) wr_addr <= pay;
      if (wr_mem && AUTO_INC) wr_addr <= wr_addr + W'(1);
      if (rd_set) begin
        rd_addr <= pay;
        rd_flag <= 1'b1;
      end
      // MISO leads tx by one bit so the MSB appears the cycle after the load
      if (rd_load) begin
        tx   <= mem[rd_addr];
        MISO <= mem[rd_addr][W-1];
      end else if (rd_shift) begin
        tx   <= tx_sh;
        MISO <= rd_done ? 1'b0 : tx_sh[W-1];
      end
      if (rd_done) begin
        if (AUTO_INC) rd_addr <= rd_addr + W'(1);
        else          rd_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_mem) mem[wr_addr] <= pay;
  end

endmodule

// File: tb/tb_spi_ram_wrapper_param.sv
// Directed frame bench: one instance without and one with address auto-increment.
module tb_spi_ram_wrapper_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ss_n = 2'b11;
  logic [1:0] mosi = 2'b00;
  logic [1:0] miso, ferr;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_ram_wrapper_param #(.W(8), .AUTO_INC(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]), .frame_err(ferr[0]));
  spi_ram_wrapper_param #(.W(8), .AUTO_INC(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]), .frame_err(ferr[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One frame on instance d. Cycle 0 is the cycle SS_n is first low.
  // err: frame_err in cycle 11; rd: MISO over cycles 12..19;
  // stray: frame_err outside cycle 11 or MISO outside 12..19 (or after an abort).
  // abort_kind 1 raises SS_n at abort_cyc, 2 pulls rst_n low at abort_cyc.
  task automatic xfer(input int d, input logic [9:0] f, input int abort_cyc, input int abort_kind,
                      output logic err, output logic [7:0] rd, output logic stray);
    err = 1'b0; rd = '0; stray = 1'b0;
    @(negedge clk); ss_n[d] = 1'b1; mosi[d] = 1'b0;
    @(negedge clk); ss_n[d] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == abort_cyc && abort_kind == 1) begin
        ss_n[d] = 1'b1;
        @(negedge clk);
        stray = miso[d] | ferr[d];
        return;
      end
      if (c == abort_cyc && abort_kind == 2) begin
        rst_n = 1'b0;
        #1;
        stray = miso[d] | ferr[d];
        @(negedge clk);
        rst_n = 1'b1;
        ss_n[d] = 1'b1;
        return;
      end
      if (c <= 10) mosi[d] = f[10-c];
      if (c == 11) err = ferr[d];
      else if (ferr[d]) stray = 1'b1;
      if (c >= 12 && c <= 19) rd[19-c] = miso[d];
      else if (miso[d]) stray = 1'b1;
    end
  endtask

  initial begin
    logic e, s;
    logic [7:0] r;
    #1;
    chk("rst_miso", miso, 0);
    chk("rst_ferr", ferr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic write then read, no auto-increment
    xfer(0, {2'b00, 8'h3C}, 0, 0, e, r, s); chk("wa_err", e, 0);
    xfer(0, {2'b01, 8'hA5}, 0, 0, e, r, s); chk("wd_stray", s, 0);
    xfer(0, {2'b10, 8'h3C}, 0, 0, e, r, s); chk("ra_err", e, 0);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s);
    chk("rd_a5", r, 8'hA5); chk("rd_err", e, 0); chk("rd_stray", s, 0);

    // address frame while flag set is rejected, address kept
    xfer(0, {2'b10, 8'h3C}, 0, 0, e, r, s);
    xfer(0, {2'b10, 8'h05}, 0, 0, e, r, s);
    chk("rej10_err", e, 1); chk("rej10_miso", r, 0); chk("rej10_stray", s, 0);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("rej10_addr", r, 8'hA5);
    // flag now clear: data read is rejected
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s);
    chk("rej11_err", e, 1); chk("rej11_miso", r, 0); chk("rej11_stray", s, 0);

    // SS_n raised mid-frame: no write
    xfer(0, {2'b01, 8'h77}, 6, 1, e, r, s); chk("abort_miso", s, 0);
    xfer(0, {2'b10, 8'h3C}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("abort_keep", r, 8'hA5);

    // no post-increment: second data write overwrites; top address
    xfer(0, {2'b00, 8'h00}, 0, 0, e, r, s);
    xfer(0, {2'b01, 8'h5A}, 0, 0, e, r, s);
    xfer(0, {2'b01, 8'hE7}, 0, 0, e, r, s);
    xfer(0, {2'b00, 8'h01}, 0, 0, e, r, s);
    xfer(0, {2'b01, 8'hC3}, 0, 0, e, r, s);
    xfer(0, {2'b00, 8'hFF}, 0, 0, e, r, s);
    xfer(0, {2'b01, 8'h96}, 0, 0, e, r, s);
    xfer(0, {2'b10, 8'h00}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("noinc_00", r, 8'hE7);
    xfer(0, {2'b10, 8'h01}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("noinc_01", r, 8'hC3);
    xfer(0, {2'b10, 8'hFF}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("noinc_ff", r, 8'h96);

    // auto-increment with wrap
    xfer(1, {2'b00, 8'hFF}, 0, 0, e, r, s);
    xfer(1, {2'b01, 8'h11}, 0, 0, e, r, s);
    xfer(1, {2'b01, 8'h22}, 0, 0, e, r, s);
    xfer(1, {2'b10, 8'hFF}, 0, 0, e, r, s);
    xfer(1, {2'b11, 8'h00}, 0, 0, e, r, s); chk("inc_ff", r, 8'h11); chk("inc_ff_err", e, 0);
    xfer(1, {2'b11, 8'hAB}, 0, 0, e, r, s); chk("inc_wrap", r, 8'h22); chk("inc_stray", s, 0);

    // reset while MISO shifts (cycle 14 carries bit 5 of A5 = 1)
    xfer(0, {2'b10, 8'h3C}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 14, 2, e, r, s); chk("rst_async_miso", s, 0);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s);
    chk("rst_flag_err", e, 1); chk("rst_flag_miso", r, 0);
    xfer(0, {2'b10, 8'h3C}, 0, 0, e, r, s);
    xfer(0, {2'b11, 8'h00}, 0, 0, e, r, s); chk("rst_mem_keep", r, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
